// File: rtl/cpu_host_bridge_if.sv
// cpu_host_bridge_if: host-side request/response handshake bundle
//   master: host (drives request word, expect flag and response ready)
//   slave : bridge (drives request ready and the registered response)
interface cpu_host_bridge_if #(parameter int DATA_W = 32);
  logic              host_req_valid;
  logic              host_req_ready;
  logic [DATA_W-1:0] host_req_data;
  logic              host_req_expect_resp;
  logic              host_resp_valid;
  logic              host_resp_ready;
  logic [DATA_W-1:0] host_resp_data;
  logic              host_resp_timeout;
  modport master (
    output host_req_valid, host_req_data, host_req_expect_resp, host_resp_ready,
    input  host_req_ready, host_resp_valid, host_resp_data, host_resp_timeout
  );
  modport slave (
    input  host_req_valid, host_req_data, host_req_expect_resp, host_resp_ready,
    output host_req_ready, host_resp_valid, host_resp_data, host_resp_timeout
  );
endinterface

// File: rtl/cpu_host_bridge.sv
// cpu_host_bridge: host-side bridge to the CPU FIFO mailbox with response tracking and timeouts
//   clk, rst (async, active-high)
//   host            : request/response handshake (slave side)
//   req_fifo_*      : write port of the CPU request FIFO
//   read_fifo_*     : show-ahead read port of the CPU result FIFO
//   cpu_halt        : sticky CPU halt, flushes outstanding responses as timeouts
//   outstanding     : expected-but-undelivered response count
//   unexpected_resp : sticky flag for a CPU word arriving with nothing outstanding
module cpu_host_bridge #(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  cpu_host_bridge_if.slave  host,
  output logic [DATA_W-1:0] req_fifo_data_in,
  output logic              req_fifo_enq,
  input  logic              req_fifo_wrfull,
  input  logic [DATA_W-1:0] read_fifo_data,
  output logic              read_fifo_deq,
  input  logic              read_fifo_rdempty,
  input  logic              cpu_halt,
  output logic [7:0]        outstanding,
  output logic              unexpected_resp
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [7:0] OMAX = 8'(MAX_OUTSTANDING);
  logic [CW-1:0]     tcnt;
  logic              resp_valid, resp_timeout;
  logic [DATA_W-1:0] resp_data;
  logic              load_ok, load_fifo, load_to, tsat, fire, inc, dec, busy;
  always_comb begin
    busy             = outstanding != 8'd0;
    host.host_req_ready = !rst && !req_fifo_wrfull && (outstanding < OMAX);
    req_fifo_enq     = host.host_req_valid && host.host_req_ready;
    req_fifo_data_in = host.host_req_data;
    load_ok          = !resp_valid || host.host_resp_ready;
    load_fifo        = load_ok && !read_fifo_rdempty;
    read_fifo_deq    = load_fifo;
    tsat             = TIMEOUT_CYCLES != 0 && tcnt == TMAX;
    fire             = busy && read_fifo_rdempty && (tsat || cpu_halt);
    // fire implies rdempty, so a timeout load never competes with a FIFO load
    load_to          = load_ok && fire;
    inc              = req_fifo_enq && host.host_req_expect_resp;
    dec              = (load_fifo && busy) || load_to;
    host.host_resp_valid   = resp_valid;
    host.host_resp_data    = resp_data;
    host.host_resp_timeout = resp_timeout;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resp_valid      <= 1'b0;
      resp_data       <= '0;
      resp_timeout    <= 1'b0;
      outstanding     <= 8'd0;
      tcnt            <= '0;
      unexpected_resp <= 1'b0;
    end else begin
      if (load_fifo) begin
        resp_valid   <= 1'b1;
        resp_data    <= read_fifo_data;
        resp_timeout <= 1'b0;
      end else if (load_to) begin
        resp_valid   <= 1'b1;
        resp_data    <= '0;
        resp_timeout <= 1'b1;
      end else if (host.host_resp_ready)
        resp_valid <= 1'b0;
      outstanding <= outstanding + 8'(inc) - 8'(dec);
      // a pending fire keeps the counter saturated until the register frees up
      if (load_fifo || load_to || !busy)
        tcnt <= '0;
      else if (TIMEOUT_CYCLES != 0 && read_fifo_rdempty && !tsat)
        tcnt <= tcnt + 1'b1;
      if (load_fifo && !busy)
        unexpected_resp <= 1'b1;
    end
endmodule
